usb_rx_pkt_decoder: RTL

//  Parametrised receive-side packet decoder; successor to the fixed DATA0/ACK/NAK decoder.

---
 rtl/usb_pkt_pkg.sv | 42 ++++
 rtl/usb_rx_pkt_decoder_if.sv | 31 +++
 rtl/usb_crc_serial.sv | 32 +++
 rtl/usb_rx_pkt_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_pkg.sv
// Shared PID/error encodings, CRC constants and packet length helpers for the USB receive path.
package usb_pkt_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE
  } pid_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_PID_BAD,
    ERR_PID_UNSUP,
    ERR_LEN,
    ERR_OVERFLOW,
    ERR_CRC
  } pkt_err_t;

  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  localparam int PID_BITS   = 8;
  localparam int HS_BITS    = 8;
  localparam int TOKEN_BITS = 24;
  localparam int DATA_MIN   = 24;

  function automatic int max_bits(input int max_bytes);
    return DATA_MIN + 8 * max_bytes;
  endfunction

  function automatic int body_sr_bits(input int max_bytes);
    return 8 * max_bytes + 16;
  endfunction

endpackage

// File: rtl/usb_rx_pkt_decoder_if.sv
// Serial bit stream from the link layer in, one decoded result per packet out.
interface usb_rx_pkt_decoder_if
  import usb_pkt_pkg::*;
#(
  parameter int MAX_BYTES = 8
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic                   recving;
  logic                   pause;
  logic                   inb;
  logic                   pkt_valid;
  logic                   pkt_error;
  pkt_err_t               err_code;
  logic [3:0]             pid;
  logic [6:0]             addr;
  logic [3:0]             endp;
  logic [8*MAX_BYTES-1:0] data;
  logic [LEN_W-1:0]       data_len;

  modport master (
    output recving, pause, inb,
    input  pkt_valid, pkt_error, err_code, pid, addr, endp, data, data_len
  );

  modport slave (
    input  recving, pause, inb,
    output pkt_valid, pkt_error, err_code, pid, addr, endp, data, data_len
  );

endinterface

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC, LSB-first stream; preset loads all-ones, en clocks one bit.
// residue_ok is combinational off the register; no backpressure.
module usb_crc_serial #(
  parameter int           W       = 5,
  parameter logic [W-1:0] POLY    = '0,
  parameter logic [W-1:0] RESIDUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic preset,
  input  logic en,
  input  logic inb,
  output logic residue_ok
);

  logic [W-1:0] crc;
  logic         fb;

  assign fb         = inb ^ crc[W-1];
  assign residue_ok = (crc == RESIDUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (preset) begin
      crc <= '1;
    end else if (en) begin
      crc <= {crc[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/usb_rx_pkt_decoder.sv
// USB receive packet decoder: PID/token/data/handshake with inline CRC5/CRC16 checks.
// Result pulse 2 clk after recving falls; input is a pure stream, pause stalls without backpressure.
module usb_rx_pkt_decoder
  import usb_pkt_pkg::*;
#(
  parameter int MAX_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  usb_rx_pkt_decoder_if.slave  bus
);

  localparam int MAX_BITS = max_bits(MAX_BYTES);
  localparam int SR_W     = body_sr_bits(MAX_BYTES);
  localparam int DAT_W    = 8 * MAX_BYTES;
  localparam int CNT_W    = $clog2(MAX_BITS + 2);
  localparam int LEN_W    = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PID, S_BODY, S_CHECK} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        pid_sr;
  logic [SR_W-1:0]   body_sr;
  logic              accept;
  logic              pkt_start, pid_shift, body_shift, cnt_inc, crc_preset, check;
  logic              crc5_ok, crc16_ok;
  logic              is_tok, is_data, is_hs;
  pkt_err_t          err;
  logic [LEN_W-1:0]  nbytes;
  logic [DAT_W-1:0]  aligned, data_nxt;

  logic              pkt_valid_q, pkt_error_q;
  pkt_err_t          err_code_q;
  logic [3:0]        pid_q;
  logic [6:0]        addr_q;
  logic [3:0]        endp_q;
  logic [DAT_W-1:0]  data_q;
  logic [LEN_W-1:0]  data_len_q;

  assign accept = bus.recving && !bus.pause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pkt_start  = 1'b0;
    pid_shift  = 1'b0;
    body_shift = 1'b0;
    cnt_inc    = 1'b0;
    crc_preset = 1'b0;
    check      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          pkt_start = 1'b1;
          pid_shift = 1'b1;
          state_nxt = S_PID;
        end
      end
      S_PID: begin
        if (!bus.recving) begin
          state_nxt = S_CHECK;
        end else if (accept) begin
          pid_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt == CNT_W'(PID_BITS - 1)) begin
            crc_preset = 1'b1;
            state_nxt  = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (!bus.recving) begin
          state_nxt = S_CHECK;
        end else if (accept) begin
          cnt_inc    = 1'b1;
          body_shift = (cnt != CNT_SAT);
        end
      end
      S_CHECK: begin
        check = 1'b1;
        // A bit arriving in the check cycle already belongs to the next packet.
        if (accept) begin
          pkt_start = 1'b1;
          pid_shift = 1'b1;
          state_nxt = S_PID;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pid_sr  <= '0;
      body_sr <= '0;
    end else begin
      if (pkt_start)                      cnt <= CNT_W'(1);
      else if (cnt_inc && cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
      if (pid_shift)  pid_sr  <= {bus.inb, pid_sr[7:1]};
      if (body_shift) body_sr <= {bus.inb, body_sr[SR_W-1:1]};
    end
  end

  usb_crc_serial #(.W(5), .POLY(CRC5_POLY), .RESIDUE(CRC5_RESIDUE)) u_crc5 (
    .clk(clk), .rst(rst), .preset(crc_preset), .en(body_shift),
    .inb(bus.inb), .residue_ok(crc5_ok)
  );

  usb_crc_serial #(.W(16), .POLY(CRC16_POLY), .RESIDUE(CRC16_RESIDUE)) u_crc16 (
    .clk(clk), .rst(rst), .preset(crc_preset), .en(body_shift),
    .inb(bus.inb), .residue_ok(crc16_ok)
  );

  always_comb begin
    is_tok  = 1'b0;
    is_data = 1'b0;
    is_hs   = 1'b0;
    case (pid_sr[3:0])
      PID_OUT, PID_IN, PID_SETUP:   is_tok  = 1'b1;
      PID_DATA0, PID_DATA1:         is_data = 1'b1;
      PID_ACK, PID_NAK, PID_STALL:  is_hs   = 1'b1;
      default: ;
    endcase

    err = ERR_NONE;
    if (cnt < CNT_W'(PID_BITS) || pid_sr[7:4] != ~pid_sr[3:0])
      err = ERR_PID_BAD;
    else if (!(is_tok || is_data || is_hs))
      err = ERR_PID_UNSUP;
    else if ((is_hs && cnt != CNT_W'(HS_BITS)) || (is_tok && cnt != CNT_W'(TOKEN_BITS)))
      err = ERR_LEN;
    else if (is_data && (cnt < CNT_W'(DATA_MIN) ||
                         (cnt[2:0] != 3'd0 && cnt <= CNT_W'(MAX_BITS))))
      err = ERR_LEN;
    else if (is_data && cnt > CNT_W'(MAX_BITS))
      err = ERR_OVERFLOW;
    else if ((is_tok && !crc5_ok) || (is_data && !crc16_ok))
      err = ERR_CRC;

    // Body bits sit at the top of the SIPO; shift the first data bit down to bit 0.
    nbytes  = LEN_W'((cnt - CNT_W'(DATA_MIN)) >> 3);
    aligned = DAT_W'(body_sr >> (CNT_W'(SR_W) - (cnt - CNT_W'(PID_BITS))));
    data_nxt = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(nbytes)) data_nxt[8*i +: 8] = aligned[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      data_q      <= '0;
      data_len_q  <= '0;
    end else begin
      pkt_valid_q <= check && (err == ERR_NONE);
      pkt_error_q <= check && (err != ERR_NONE);
      if (check) begin
        err_code_q <= err;
        if (err == ERR_NONE) begin
          pid_q      <= pid_sr[3:0];
          addr_q     <= is_tok ? body_sr[SR_W-16 +: 7] : 7'd0;
          endp_q     <= is_tok ? body_sr[SR_W-9 +: 4] : 4'd0;
          data_q     <= is_data ? data_nxt : '0;
          data_len_q <= is_data ? nbytes : '0;
        end else if (err == ERR_PID_UNSUP) begin
          pid_q <= pid_sr[3:0];
        end
      end
    end
  end

  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_error = pkt_error_q;
  assign bus.err_code  = err_code_q;
  assign bus.pid       = pid_q;
  assign bus.addr      = addr_q;
  assign bus.endp      = endp_q;
  assign bus.data      = data_q;
  assign bus.data_len  = data_len_q;

endmodule
